ps2_rx_seq: RTL and testbench

PS/2 receive sequencer feeding the keyboard scancode decoder. Samples the raw PS/2 clock and data lines, assembles 11-bit device-to-host frames, checks parity and stop bit, and buffers good bytes in a small FIFO. Drains each buffered byte to the decoder's nibble port as a low-nibble strobe followed by a high-nibble strobe. Sits between the board PS/2 pins and the scancode-to-ASCII/interrupt block.

---
 rtl/ps2_rx_seq.sv | 233 +++++++++++++++++++++++
 tb/tb_ps2_rx_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_seq.sv
// PS/2 device-to-host receiver: conditions the pins, checks each 11-bit frame,
// buffers good bytes, and hands them to the decoder as a low/high nibble pair.
module ps2_rx_seq #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 100000,
  parameter int unsigned FIFO_AW        = 3,
  parameter int unsigned GAP_CYCLES     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               ps2_clk,
  input  logic               ps2_data,
  input  logic               hold,
  output logic               kbd_enb_lo,
  output logic               kbd_enb_hi,
  output logic [3:0]         kbd_data,
  output logic               parity_err,
  output logic               frame_err,
  output logic               overflow,
  output logic [FIFO_AW:0]   fifo_count
);

  localparam int unsigned FCW   = $clog2(FILTER_LEN + 1);
  localparam int unsigned TOW   = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned GW    = $clog2(GAP_CYCLES + 2);
  localparam int unsigned CW    = FIFO_AW + 1;
  localparam int unsigned DEPTH = 2 ** FIFO_AW;

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} frame_t;
  typedef enum logic [1:0] {D_IDLE, D_LO, D_HI, D_GAP} deliv_t;

  // ---------------- input conditioning ----------------
  logic [1:0]     r_clk_s, r_dat_s;
  logic           r_filt, r_filt_d;
  logic [FCW-1:0] r_fcnt;
  logic           w_sample, w_bit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_clk_s  <= '1;
      r_dat_s  <= '1;
      r_filt   <= 1'b1;
      r_filt_d <= 1'b1;
      r_fcnt   <= '0;
    end else begin
      r_clk_s  <= {r_clk_s[0], ps2_clk};
      r_dat_s  <= {r_dat_s[0], ps2_data};
      r_filt_d <= r_filt;
      if (r_clk_s[1] == r_filt) begin
        r_fcnt <= '0;
      end else if (r_fcnt == FCW'(FILTER_LEN - 1)) begin
        r_filt <= r_clk_s[1];
        r_fcnt <= '0;
      end else begin
        r_fcnt <= r_fcnt + FCW'(1);
      end
    end
  end

  assign w_sample = r_filt_d & ~r_filt;
  assign w_bit    = r_dat_s[1];

  // ---------------- frame FSM ----------------
  frame_t         r_fstate, w_fnext;
  logic [7:0]     r_shift;
  logic [2:0]     r_bitcnt;
  logic           r_par;
  logic [TOW-1:0] r_to;
  logic           w_timeout, w_par_ok, w_push, w_perr, w_ferr;

  assign w_timeout = (r_fstate != IDLE) && !w_sample && (r_to == TOW'(TIMEOUT_CYCLES - 1));
  assign w_par_ok  = ^{r_shift, r_par};

  always_ff @(posedge clk) begin
    if (rst) r_fstate <= IDLE;
    else     r_fstate <= w_fnext;
  end

  always_comb begin
    w_fnext = r_fstate;
    if (w_timeout) begin
      w_fnext = IDLE;
    end else if (w_sample) begin
      case (r_fstate)
        IDLE:    if (!w_bit) w_fnext = DATA;
        DATA:    if (r_bitcnt == 3'd7) w_fnext = PARITY;
        PARITY:  w_fnext = STOP;
        default: w_fnext = IDLE;
      endcase
    end
  end

  // Stop-bit failure takes precedence over a parity failure.
  always_comb begin
    w_push = 1'b0;
    w_perr = 1'b0;
    w_ferr = 1'b0;
    if (w_timeout) begin
      w_ferr = 1'b1;
    end else if (w_sample) begin
      case (r_fstate)
        IDLE: w_ferr = w_bit;
        STOP: begin
          if (!w_bit)         w_ferr = 1'b1;
          else if (!w_par_ok) w_perr = 1'b1;
          else                w_push = 1'b1;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_shift  <= '0;
      r_bitcnt <= '0;
      r_par    <= 1'b0;
      r_to     <= '0;
    end else begin
      if (w_sample || r_fstate == IDLE) r_to <= '0;
      else                              r_to <= r_to + TOW'(1);
      if (w_sample) begin
        case (r_fstate)
          IDLE:   r_bitcnt <= '0;
          DATA: begin
            r_shift  <= {w_bit, r_shift[7:1]};
            r_bitcnt <= r_bitcnt + 3'd1;
          end
          PARITY: r_par <= w_bit;
          default: ;
        endcase
      end
    end
  end

  // ---------------- FIFO ----------------
  logic [7:0]         r_mem [DEPTH];
  logic [FIFO_AW-1:0] r_wr, r_rd;
  logic [CW-1:0]      r_count;
  logic               w_pop, w_wr, w_ovf;
  logic [7:0]         w_head;

  deliv_t r_dstate, w_dnext;

  assign w_pop  = (r_dstate == D_HI);
  assign w_wr   = w_push && ((r_count != CW'(DEPTH)) || w_pop);
  assign w_ovf  = w_push && !w_wr;
  assign w_head = r_mem[r_rd];

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr] <= r_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr    <= '0;
      r_rd    <= '0;
      r_count <= '0;
    end else begin
      if (w_wr)  r_wr <= r_wr + FIFO_AW'(1);
      if (w_pop) r_rd <= r_rd + FIFO_AW'(1);
      case ({w_wr, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: ;
      endcase
    end
  end

  // ---------------- delivery FSM ----------------
  logic [GW-1:0] r_gap;
  logic          w_lo, w_hi;
  logic [3:0]    w_data;
  logic          r_enb_lo, r_enb_hi, r_perr, r_ferr, r_ovf;
  logic [3:0]    r_data;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dstate <= D_IDLE;
      r_gap    <= '0;
    end else begin
      r_dstate <= w_dnext;
      if (r_dstate == D_GAP) r_gap <= r_gap + GW'(1);
      else                   r_gap <= '0;
    end
  end

  always_comb begin
    w_dnext = r_dstate;
    case (r_dstate)
      D_IDLE:  if (r_count != '0 && !hold) w_dnext = D_LO;
      D_LO:    w_dnext = D_HI;
      D_HI:    w_dnext = (GAP_CYCLES == 0) ? D_IDLE : D_GAP;
      default: if (r_gap == GW'(GAP_CYCLES - 1)) w_dnext = D_IDLE;
    endcase
  end

  // Outputs decode the next state so each strobe registers in the cycle its state is held.
  always_comb begin
    w_lo   = (w_dnext == D_LO);
    w_hi   = (w_dnext == D_HI);
    w_data = '0;
    if (w_lo)      w_data = w_head[3:0];
    else if (w_hi) w_data = w_head[7:4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_enb_lo <= 1'b0;
      r_enb_hi <= 1'b0;
      r_data   <= '0;
      r_perr   <= 1'b0;
      r_ferr   <= 1'b0;
      r_ovf    <= 1'b0;
    end else begin
      r_enb_lo <= w_lo;
      r_enb_hi <= w_hi;
      r_data   <= w_data;
      r_perr   <= w_perr;
      r_ferr   <= w_ferr;
      r_ovf    <= w_ovf;
    end
  end

  assign kbd_enb_lo = r_enb_lo;
  assign kbd_enb_hi = r_enb_hi;
  assign kbd_data   = r_data;
  assign parity_err = r_perr;
  assign frame_err  = r_ferr;
  assign overflow   = r_ovf;
  assign fifo_count = r_count;

endmodule

// File: tb/tb_ps2_rx_seq.sv
// Directed bench for ps2_rx_seq: frame vector table plus hand-written
// timeout, overflow, glitch and reset sequences.
module tb_ps2_rx_seq;

  localparam int FL   = 8;
  localparam int TO   = 300;
  localparam int AW   = 2;
  localparam int GAP  = 2;
  localparam int HALF = 20;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ps2_clk = 1'b1;
  logic         ps2_data = 1'b1;
  logic         hold = 1'b0;
  logic         kbd_enb_lo, kbd_enb_hi, parity_err, frame_err, overflow;
  logic [3:0]   kbd_data;
  logic [AW:0]  fifo_count;

  ps2_rx_seq #(
    .FILTER_LEN(FL),
    .TIMEOUT_CYCLES(TO),
    .FIFO_AW(AW),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .ps2_clk(ps2_clk),
    .ps2_data(ps2_data),
    .hold(hold),
    .kbd_enb_lo(kbd_enb_lo),
    .kbd_enb_hi(kbd_enb_hi),
    .kbd_data(kbd_data),
    .parity_err(parity_err),
    .frame_err(frame_err),
    .overflow(overflow),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  int lo_nib[$], lo_cyc[$], hi_nib[$], hi_cyc[$];
  int perr_n, ferr_n, ovf_n, ferr_cyc;
  int both_n = 0;
  int idle_data_n = 0;

  always @(negedge clk) begin
    if (kbd_enb_lo) begin lo_nib.push_back(int'(kbd_data)); lo_cyc.push_back(cyc); end
    if (kbd_enb_hi) begin hi_nib.push_back(int'(kbd_data)); hi_cyc.push_back(cyc); end
    if (kbd_enb_lo && kbd_enb_hi) both_n++;
    if (!kbd_enb_lo && !kbd_enb_hi && kbd_data != 4'd0) idle_data_n++;
    if (parity_err) perr_n++;
    if (frame_err) begin ferr_n++; ferr_cyc = cyc; end
    if (overflow) ovf_n++;
  end

  typedef struct {
    logic [7:0] data;
    logic       par;
    logic       stp;
    int         exp_ok;
    int         exp_perr;
    int         exp_ferr;
    int         exp_lo;
    int         exp_hi;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_log();
    lo_nib.delete(); lo_cyc.delete(); hi_nib.delete(); hi_cyc.delete();
    perr_n = 0; ferr_n = 0; ovf_n = 0; ferr_cyc = -1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_data = b;
    wait_cyc(HALF);
    ps2_clk = 1'b0;
    wait_cyc(HALF);
    ps2_clk = 1'b1;
  endtask

  task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(d[i]);
    ps2_bit(p);
    ps2_bit(s);
    ps2_data = 1'b1;
    wait_cyc(HALF);
  endtask

  function automatic int qget(input int q[$], input int idx);
    return (idx < q.size()) ? q[idx] : -1;
  endfunction

  initial begin
    //         data   par   stp  ok perr ferr lo  hi
    vecs[0] = '{8'h1C, 1'b0, 1'b1, 1, 0, 0, 'hC, 'h1};
    vecs[1] = '{8'hF0, 1'b0, 1'b1, 0, 1, 0, 0,   0};
    vecs[2] = '{8'h12, 1'b1, 1'b0, 0, 0, 1, 0,   0};
    vecs[3] = '{8'h12, 1'b1, 1'b1, 1, 0, 0, 'h2, 'h1};
    vecs[4] = '{8'h59, 1'b1, 1'b1, 1, 0, 0, 'h9, 'h5};
    vecs[5] = '{8'h00, 1'b1, 1'b1, 1, 0, 0, 'h0, 'h0};
    vecs[6] = '{8'hFF, 1'b1, 1'b1, 1, 0, 0, 'hF, 'hF};
    vecs[7] = '{8'hA5, 1'b0, 1'b1, 0, 1, 0, 0,   0};
    vecs[8] = '{8'h80, 1'b0, 1'b0, 0, 0, 1, 0,   0};

    clr_log();
    wait_cyc(4);
    chk("reset_outputs", int'({kbd_enb_lo, kbd_enb_hi, kbd_data, parity_err, frame_err, overflow}), 0);
    chk("reset_count", int'(fifo_count), 0);
    rst = 1'b0;
    wait_cyc(4);

    for (int v = 0; v < 9; v++) begin
      clr_log();
      send_frame(vecs[v].data, vecs[v].par, vecs[v].stp);
      wait_cyc(30);
      chk($sformatf("v%0d_lo_cnt", v), lo_nib.size(), vecs[v].exp_ok);
      chk($sformatf("v%0d_hi_cnt", v), hi_nib.size(), vecs[v].exp_ok);
      if (vecs[v].exp_ok != 0) begin
        chk($sformatf("v%0d_lo_nib", v), qget(lo_nib, 0), vecs[v].exp_lo);
        chk($sformatf("v%0d_hi_nib", v), qget(hi_nib, 0), vecs[v].exp_hi);
        chk($sformatf("v%0d_hi_after_lo", v), qget(hi_cyc, 0) - qget(lo_cyc, 0), 1);
      end
      chk($sformatf("v%0d_perr", v), perr_n, vecs[v].exp_perr);
      chk($sformatf("v%0d_ferr", v), ferr_n, vecs[v].exp_ferr);
      chk($sformatf("v%0d_count", v), int'(fifo_count), 0);
    end

    // Timeout: start + 3 data bits, then the clock stops.
    begin
      int tfall;
      int waited;
      clr_log();
      ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
      tfall = cyc - HALF;
      ps2_data = 1'b1;
      waited = 0;
      while (ferr_n == 0 && waited < TO + 60) begin wait_cyc(1); waited++; end
      chk("timeout_seen", ferr_n, 1);
      chk("timeout_early", int'(ferr_cyc - tfall >= TO + 2), 1);
      chk("timeout_late", int'(ferr_cyc - tfall <= TO + FL + 8), 1);
      wait_cyc(10);
      chk("timeout_single", ferr_n, 1);
      chk("timeout_no_strobe", lo_nib.size(), 0);
      clr_log();
      send_frame(8'h59, 1'b1, 1'b1);
      wait_cyc(30);
      chk("post_to_lo", qget(lo_nib, 0), 'h9);
      chk("post_to_hi", qget(hi_nib, 0), 'h5);
      chk("post_to_ferr", ferr_n, 0);
    end

    // Overflow with hold asserted, then drain in order.
    clr_log();
    hold = 1'b1;
    for (int b = 1; b <= 4; b++) send_frame(8'(b), ~^(8'(b)), 1'b1);
    wait_cyc(10);
    chk("fifo_full_count", int'(fifo_count), 4);
    chk("fifo_no_ovf_yet", ovf_n, 0);
    send_frame(8'h05, ~^(8'h05), 1'b1);
    wait_cyc(10);
    chk("ovf_pulse", ovf_n, 1);
    chk("ovf_count", int'(fifo_count), 4);
    chk("hold_no_strobe", lo_nib.size(), 0);
    hold = 1'b0;
    wait_cyc(40);
    chk("drain_lo_cnt", lo_nib.size(), 4);
    chk("drain_hi_cnt", hi_nib.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("drain%0d_lo", i), qget(lo_nib, i), i + 1);
      chk($sformatf("drain%0d_hi", i), qget(hi_nib, i), 0);
      if (i > 0) chk($sformatf("drain%0d_gap", i), qget(lo_cyc, i) - qget(lo_cyc, i - 1), 3 + GAP);
    end
    chk("drain_count", int'(fifo_count), 0);

    // Short glitch on ps2_clk must not produce a sample point.
    clr_log();
    ps2_clk = 1'b0;
    wait_cyc(3);
    ps2_clk = 1'b1;
    wait_cyc(30);
    chk("glitch_ferr", ferr_n, 0);
    chk("glitch_strobe", lo_nib.size(), 0);

    // Reset mid-frame with a buffered byte pending.
    clr_log();
    hold = 1'b1;
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_cyc(5);
    chk("pre_rst_count", int'(fifo_count), 1);
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    rst = 1'b1;
    wait_cyc(3);
    chk("rst_outputs", int'({kbd_enb_lo, kbd_enb_hi, kbd_data, parity_err, frame_err, overflow}), 0);
    chk("rst_count", int'(fifo_count), 0);
    rst = 1'b0;
    hold = 1'b0;
    wait_cyc(10);
    chk("post_rst_idle", lo_nib.size(), 0);
    clr_log();
    send_frame(8'h1C, 1'b0, 1'b1);
    wait_cyc(30);
    chk("post_rst_lo_cnt", lo_nib.size(), 1);
    chk("post_rst_lo", qget(lo_nib, 0), 'hC);
    chk("post_rst_hi", qget(hi_nib, 0), 'h1);
    chk("post_rst_err", perr_n + ferr_n + ovf_n, 0);

    chk("lo_hi_overlap", both_n, 0);
    chk("idle_data_zero", idle_data_n, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

endmodule
